// File: rtl/id_ex_operand_stage_if.sv
// ID-to-EX operand bus: ID-side instruction/control inputs and the registered EX-side operand fields.
// The master drives the ID side and consumes EX; the slave (the stage itself) does the reverse.
interface id_ex_operand_stage_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            instr_in;
    logic [31:0]            pc_in;
    logic                   valid_in;
    logic                   stall;
    logic                   flush;
    logic [2:0]             Si;
    logic [11:0]            imm12_I;
    logic [11:0]            imm12_S;
    logic [19:0]            imm20;
    logic [31:0]            PC;
    logic                   valid_out;
    logic                   illegal;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output instr_in, pc_in, valid_in, stall, flush,
        input  Si, imm12_I, imm12_S, imm20, PC, valid_out, illegal, stall_cycles
    );

    modport slave (
        input  instr_in, pc_in, valid_in, stall, flush,
        output Si, imm12_I, imm12_S, imm20, PC, valid_out, illegal, stall_cycles
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID->EX register stage: decodes the second-operand select and raw immediates and registers them into EX.
// Supports stall (hold), flush (bubble) and a saturating stall-cycle counter.
module id_ex_operand_stage #(
    parameter int STALL_CNT_W = 16
) (
    input logic                  clk,
    input logic                  reset,
    id_ex_operand_stage_if.slave bus
);
    localparam logic [2:0] SI_PB   = 3'b000;
    localparam logic [2:0] SI_IMMI = 3'b001;
    localparam logic [2:0] SI_IMMS = 3'b010;
    localparam logic [2:0] SI_IMM20 = 3'b011;
    localparam logic [2:0] SI_PC   = 3'b100;

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [6:0] opcode;
    logic [2:0] si_dec;
    logic       unknown_op;

    assign opcode = bus.instr_in[6:0];

    always_comb begin
        si_dec     = SI_PB;
        unknown_op = 1'b0;
        case (opcode)
            7'b0110011, 7'b1100011:             si_dec = SI_PB;
            7'b0010011, 7'b0000011, 7'b1100111: si_dec = SI_IMMI;
            7'b0100011:                         si_dec = SI_IMMS;
            7'b0110111:                         si_dec = SI_IMM20;
            7'b0010111, 7'b1101111:             si_dec = SI_PC;
            default:                            unknown_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Si           <= '0;
            bus.imm12_I      <= '0;
            bus.imm12_S      <= '0;
            bus.imm20        <= '0;
            bus.PC           <= '0;
            bus.valid_out    <= 1'b0;
            bus.illegal      <= 1'b0;
            bus.stall_cycles <= '0;
        end else if (bus.flush || (!bus.stall && !bus.valid_in)) begin
            // Flush and an empty ID slot both load a bubble; the stall counter is untouched.
            bus.Si        <= '0;
            bus.imm12_I   <= '0;
            bus.imm12_S   <= '0;
            bus.imm20     <= '0;
            bus.PC        <= '0;
            bus.valid_out <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (bus.stall) begin
            if (bus.stall_cycles != CNT_MAX) begin
                bus.stall_cycles <= bus.stall_cycles + CNT_ONE;
            end
        end else begin
            bus.Si        <= si_dec;
            bus.imm12_I   <= bus.instr_in[31:20];
            bus.imm12_S   <= {bus.instr_in[31:25], bus.instr_in[11:7]};
            bus.imm20     <= bus.instr_in[31:12];
            bus.PC        <= bus.pc_in;
            bus.valid_out <= 1'b1;
            bus.illegal   <= unknown_op;
        end
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: decode table, latency, stall/flush priority and counter saturation.
module tb_id_ex_operand_stage;
    logic clk;
    logic reset_a;
    logic reset_b;
    int   n_checks;
    int   n_errors;

    id_ex_operand_stage_if #(.STALL_CNT_W(16)) bus_a ();
    id_ex_operand_stage_if #(.STALL_CNT_W(4))  bus_b ();

    id_ex_operand_stage #(.STALL_CNT_W(16)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a.slave));
    id_ex_operand_stage #(.STALL_CNT_W(4))  dut_b (.clk(clk), .reset(reset_b), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] instr, input logic [31:0] pc, input logic v,
                           input logic st, input logic fl);
        bus_a.instr_in = instr;
        bus_a.pc_in    = pc;
        bus_a.valid_in = v;
        bus_a.stall    = st;
        bus_a.flush    = fl;
    endtask

    logic [6:0] op_tab [5];
    logic [2:0] si_tab [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        op_tab[0] = 7'b1101111; si_tab[0] = 3'b100;
        op_tab[1] = 7'b1100011; si_tab[1] = 3'b000;
        op_tab[2] = 7'b0000011; si_tab[2] = 3'b001;
        op_tab[3] = 7'b1100111; si_tab[3] = 3'b001;
        op_tab[4] = 7'b0110011; si_tab[4] = 3'b000;

        reset_a = 1'b1;
        reset_b = 1'b1;
        drive_a(32'hFFC10093, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        bus_b.instr_in = 32'hABCDE1B7;
        bus_b.pc_in    = 32'h0000_0100;
        bus_b.valid_in = 1'b1;
        bus_b.stall    = 1'b1;
        bus_b.flush    = 1'b0;
        step();
        step();
        check("rst_si",    32'(bus_a.Si), 32'h0);
        check("rst_immi",  32'(bus_a.imm12_I), 32'h0);
        check("rst_imms",  32'(bus_a.imm12_S), 32'h0);
        check("rst_imm20", 32'(bus_a.imm20), 32'h0);
        check("rst_pc",    bus_a.PC, 32'h0);
        check("rst_valid", 32'(bus_a.valid_out), 32'h0);
        check("rst_ill",   32'(bus_a.illegal), 32'h0);
        check("rst_cnt",   32'(bus_a.stall_cycles), 32'h0);
        check("rst_cnt_b", 32'(bus_b.stall_cycles), 32'h0);

        reset_a = 1'b0;
        drive_a(32'hFFC10093, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
        step();
        check("addi_si",    32'(bus_a.Si), 32'h1);
        check("addi_immi",  32'(bus_a.imm12_I), 32'hFFC);
        check("addi_imms",  32'(bus_a.imm12_S), 32'hFE1);
        check("addi_imm20", 32'(bus_a.imm20), 32'hFFC10);
        check("addi_pc",    bus_a.PC, 32'h40);
        check("addi_valid", 32'(bus_a.valid_out), 32'h1);
        check("addi_ill",   32'(bus_a.illegal), 32'h0);

        drive_a(32'h00512423, 32'h0000_0044, 1'b1, 1'b0, 1'b0);
        #2;
        check("nocomb_si", 32'(bus_a.Si), 32'h1);
        step();
        check("sw_si",   32'(bus_a.Si), 32'h2);
        check("sw_imms", 32'(bus_a.imm12_S), 32'h008);
        check("sw_immi", 32'(bus_a.imm12_I), 32'h005);
        check("sw_pc",   bus_a.PC, 32'h44);
        drive_a(32'hABCDE1B7, 32'h0000_0048, 1'b1, 1'b0, 1'b0);
        step();
        check("lui_si",    32'(bus_a.Si), 32'h3);
        check("lui_imm20", 32'(bus_a.imm20), 32'hABCDE);
        drive_a(32'h00001097, 32'h0000_004C, 1'b1, 1'b0, 1'b0);
        step();
        check("auipc_si",    32'(bus_a.Si), 32'h4);
        check("auipc_imm20", 32'(bus_a.imm20), 32'h00001);
        check("auipc_pc",    bus_a.PC, 32'h4C);

        for (int i = 0; i < 5; i++) begin
            drive_a({25'h0, op_tab[i]}, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
            step();
            check($sformatf("tab_si_%0d", i), 32'(bus_a.Si), 32'(si_tab[i]));
            check($sformatf("tab_ill_%0d", i), 32'(bus_a.illegal), 32'h0);
        end

        drive_a(32'hFFC10093, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
        step();
        drive_a(32'h00512423, 32'h0000_0044, 1'b1, 1'b1, 1'b0);
        repeat (3) step();
        check("stall_si",    32'(bus_a.Si), 32'h1);
        check("stall_immi",  32'(bus_a.imm12_I), 32'hFFC);
        check("stall_pc",    bus_a.PC, 32'h40);
        check("stall_valid", 32'(bus_a.valid_out), 32'h1);
        check("stall_cnt",   32'(bus_a.stall_cycles), 32'h3);
        drive_a(32'h00512423, 32'h0000_0044, 1'b1, 1'b1, 1'b1);
        step();
        check("flush_valid", 32'(bus_a.valid_out), 32'h0);
        check("flush_si",    32'(bus_a.Si), 32'h0);
        check("flush_imms",  32'(bus_a.imm12_S), 32'h0);
        check("flush_pc",    bus_a.PC, 32'h0);
        check("flush_cnt",   32'(bus_a.stall_cycles), 32'h3);

        drive_a(32'h0000007F, 32'h0000_0050, 1'b1, 1'b0, 1'b0);
        step();
        check("unk_si",    32'(bus_a.Si), 32'h0);
        check("unk_ill",   32'(bus_a.illegal), 32'h1);
        check("unk_valid", 32'(bus_a.valid_out), 32'h1);
        check("unk_pc",    bus_a.PC, 32'h50);
        drive_a(32'h0000007F, 32'h0000_0050, 1'b0, 1'b0, 1'b0);
        step();
        check("unk_nv_ill",   32'(bus_a.illegal), 32'h0);
        check("unk_nv_valid", 32'(bus_a.valid_out), 32'h0);
        check("unk_nv_pc",    bus_a.PC, 32'h0);

        drive_a(32'hABCDE1B7, 32'h0000_0060, 1'b1, 1'b0, 1'b0);
        step();
        drive_a(32'hABCDE1B7, 32'h0000_0060, 1'b1, 1'b1, 1'b0);
        step();
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        check("rst_mid_valid", 32'(bus_a.valid_out), 32'h0);
        check("rst_mid_si",    32'(bus_a.Si), 32'h0);
        check("rst_mid_cnt",   32'(bus_a.stall_cycles), 32'h0);

        reset_b = 1'b0;
        repeat (10) step();
        check("sat_cnt_10", 32'(bus_b.stall_cycles), 32'd10);
        repeat (5) step();
        check("sat_cnt_15", 32'(bus_b.stall_cycles), 32'd15);
        repeat (5) step();
        check("sat_cnt_20", 32'(bus_b.stall_cycles), 32'd15);
        check("sat_valid",  32'(bus_b.valid_out), 32'h0);
        reset_b = 1'b1;
        step();
        check("sat_rst_cnt", 32'(bus_b.stall_cycles), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
